// File: rtl/inst_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words and streams them
// through a small FIFO into instruction memory, starting at a latched base address.
`timescale 1ns/1ps
module inst_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_sa,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              wrap,
   output logic [ADDR_W:0]   word_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_next;
   logic               enc_valid;
   logic [31:0]        enc_word;
   logic [31:0]        fifo_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]     count;
   logic [PTR_W+1:0]   occupancy;
   logic [ADDR_W-1:0]  addr_ptr;
   logic [31:0]        word_next;
   logic               op_ok;
   logic               accept, push, pop, start_load;

   // Occupancy includes the encode stage so an accepted word always has a FIFO slot.
   assign occupancy  = {1'b0, count} + {{(PTR_W+1){1'b0}}, enc_valid};
   assign in_ready   = (state == RUN) && (occupancy < (PTR_W+2)'(DEPTH));
   assign accept     = in_valid && in_ready;
   assign push       = enc_valid;
   assign pop        = (count != '0);
   assign start_load = start && ((state == IDLE) || (state == DONE));
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: if (start)  state_next = RUN;
         RUN:        if (finish) state_next = DRAIN;
         DRAIN:      if (!enc_valid && (count == '0)) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      word_next = '0;
      op_ok     = 1'b1;
      unique case (in_op)
         5'd0:  word_next = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
         5'd1:  word_next = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
         5'd2:  word_next = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
         5'd3:  word_next = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
         5'd4:  word_next = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
         5'd5:  word_next = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h00};
         5'd6:  word_next = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h02};
         5'd7:  word_next = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h03};
         5'd8:  word_next = {6'h00, in_rs, 15'd0, 6'h08};
         5'd9:  word_next = {6'h08, in_rs, in_rt, in_imm};
         5'd10: word_next = {6'h0C, in_rs, in_rt, in_imm};
         5'd11: word_next = {6'h0D, in_rs, in_rt, in_imm};
         5'd12: word_next = {6'h0E, in_rs, in_rt, in_imm};
         5'd13: word_next = {6'h23, in_rs, in_rt, in_imm};
         5'd14: word_next = {6'h2B, in_rs, in_rt, in_imm};
         5'd15: word_next = {6'h04, in_rs, in_rt, in_imm};
         5'd16: word_next = {6'h05, in_rs, in_rt, in_imm};
         5'd17: word_next = {6'h0F, 5'd0, in_rt, in_imm};
         5'd18: word_next = {6'h02, in_target};
         5'd19: word_next = {6'h03, in_target};
         default: op_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= enc_word;
   end

   // Pop is unconditional whenever the FIFO holds a word, so the write port never stalls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         enc_valid  <= 1'b0;
         enc_word   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         addr_ptr   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         err        <= 1'b0;
         wrap       <= 1'b0;
         word_count <= '0;
      end else begin
         state     <= state_next;
         enc_valid <= accept && op_ok;
         imem_we   <= pop;
         if (start_load) begin
            addr_ptr   <= base_addr;
            err        <= 1'b0;
            wrap       <= 1'b0;
            word_count <= '0;
         end
         if (accept && op_ok)  enc_word <= word_next;
         if (accept && !op_ok) err <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            imem_wdata <= fifo_mem[rd_ptr];
            imem_addr  <= addr_ptr;
            addr_ptr   <= addr_ptr + 1'b1;
            if (addr_ptr == '1) wrap <= 1'b1;
            if (word_count != COUNT_MAX) word_count <= word_count + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
